frame_writer: RTL and testbench
===============================

FRAME_WRITER -- requirements
Module: frame_writer

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 240, visible pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 160, visible lines per frame.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, pixel FIFO entries (power of two, at least 2).
REQ-004 SHALL have port clock, input, 1, sole clock for all logic.
REQ-005 SHALL have port reset, input, 1; one clock; reset is asynchronous and active-high.
REQ-006 SHALL have port pix_valid, input, 1, pixel strobe from the raster driver (one per step).
REQ-007 SHALL have port pix_color, input, 15, BGR555 pixel colour: [4:0] R, [9:5] G, [14:10] B.
REQ-008 SHALL have port hcount, input, 9, raster column of the current pixel.
REQ-009 SHALL have port vcount, input, 8, raster row of the current pixel.
REQ-010 SHALL have port fb_ready, input, 1, framebuffer accepts a write this cycle.
REQ-011 SHALL have port fb_we, output, 1, framebuffer write strobe.
REQ-012 SHALL have port fb_addr, output, 17, linear framebuffer word address.
REQ-013 SHALL have port fb_data, output, 15, colour to write.
REQ-014 SHALL have port fb_wsel, output, 1, buffer being written; the display buffer is ~fb_wsel.
REQ-015 SHALL have port frame_done, output, 1, one-cycle pulse when buffers swap.
REQ-016 SHALL have port overflow, output, 1, sticky flag set when a pixel is dropped.

Function
REQ-017 SHALL accept a pixel only when pix_valid=1, hcount<H_ACTIVE, vcount<V_ACTIVE, the FIFO is not full, and state is ACTIVE.
REQ-018 SHALL compute the address as vcount*H_ACTIVE+hcount in 17 bits, with maximum 38399 at default parameters, using no multiplier (shift and subtract).
REQ-019 SHALL push {addr, color} into the FIFO on accept.
REQ-020 SHALL, when the FIFO is non-empty and fb_ready=1, pop the head and drive fb_we=1 with fb_addr and fb_data registered for exactly one cycle.
REQ-021 SHALL give a latency of exactly 1 cycle from accept to fb_we when the FIFO is empty and fb_ready=1; a simultaneous push and pop on an empty FIFO SHALL forward the pixel.
REQ-022 SHALL, when fb_ready=0, hold fb_we=0 and keep the FIFO contents.
REQ-023 SHALL, when a qualifying pixel arrives with the FIFO full and no pop that cycle, drop the pixel and set overflow; a pop in the same cycle frees the slot and the pixel SHALL be accepted.
REQ-024 SHALL use four states: WAIT_SOF, ACTIVE, FLUSH, SWAP.
REQ-025 WAIT_SOF SHALL go to ACTIVE on a qualifying pixel at (0,0), and that pixel SHALL be accepted in the same cycle.
REQ-026 ACTIVE SHALL go to FLUSH when pixel (V_ACTIVE-1, H_ACTIVE-1) is accepted.
REQ-027 ACTIVE SHALL also go to FLUSH if a qualifying (0,0) pixel arrives; that pixel SHALL be dropped and overflow set.
REQ-028 FLUSH SHALL go to SWAP when the FIFO is empty and no write is pending.
REQ-029 SWAP SHALL last one cycle, toggle fb_wsel, pulse frame_done=1, then return to WAIT_SOF.
REQ-030 SHALL ignore pixels in WAIT_SOF other than (0,0), and all pixels in FLUSH and SWAP, without setting overflow.
REQ-031 SHALL clear overflow only on reset.

Reset
REQ-032 SHALL, on reset assertion, immediately force state WAIT_SOF, FIFO empty, fb_we=0, fb_addr=0, fb_data=0, fb_wsel=0, frame_done=0, overflow=0.
REQ-033 SHALL discard pending FIFO entries on reset mid-frame without issuing any write.
REQ-034 SHALL, after reset deasserts, take no write until the next (0,0) pixel.

Structure
REQ-035 SHALL place H_ACTIVE/V_ACTIVE defaults, the address width (17), and the state enum type in shared package gfx_fb_pkg.
REQ-036 SHALL implement the FIFO as sub-module fb_wr_fifo: synchronous, 32-bit entries, full/empty flags, same clock/reset.

Verification
REQ-037 Full frame with fb_ready=1 -> 38400 writes with addresses 0..38399 in order, frame_done pulses once, fb_wsel goes 0->1, overflow=0.
REQ-038 Pixel (1,5) color 15'h7C1F with fb_ready=1 and empty FIFO -> next cycle fb_we=1, fb_addr=245, fb_data=7C1F.
REQ-039 Hold fb_ready=0 for 6 qualifying pixels -> 4 buffered, 2 dropped, overflow=1; on fb_ready=1 -> 4 writes in order.
REQ-040 Out-of-range pixels (hcount=240, vcount=10) and (vcount=160) -> no write, no overflow.
REQ-041 Assert reset with 3 entries queued mid-frame -> no further fb_we, all outputs 0, no writes until the next (0,0).
REQ-042 Last pixel accepted while fb_ready=0 -> FSM stays in FLUSH, frame_done held 0; on fb_ready=1 the FIFO drains, then a 1-cycle frame_done pulse and fb_wsel toggles.

Source files
------------

// File: rtl/gfx_fb_pkg.sv
// Shared framebuffer-writer types: raster defaults, address/colour widths, FSM states,
// and the constant-multiply helper used for the row base address.
package gfx_fb_pkg;
    localparam int H_ACTIVE_DEF = 240;
    localparam int V_ACTIVE_DEF = 160;
    localparam int ADDR_W       = 17;
    localparam int COLOR_W      = 15;
    localparam int ENTRY_W      = ADDR_W + COLOR_W;

    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        ACTIVE   = 2'd1,
        FLUSH    = 2'd2,
        SWAP     = 2'd3
    } fw_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic [COLOR_W-1:0] color;
    } fb_entry_t;

    // v * k for a constant k, built only from shifts and adds of v.
    function automatic logic [ADDR_W-1:0] shift_add(input logic [7:0] v, input int k);
        logic [ADDR_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < ADDR_W; i++) begin
            if (k[i]) acc = acc + (ADDR_W'(v) << i);
        end
        return acc;
    endfunction
endpackage

// File: rtl/fb_wr_fifo.sv
// Small synchronous FIFO for pending framebuffer writes; combinational head, no latency.
// A push while full is taken only when a pop happens in the same cycle.
module fb_wr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == (PW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (PW+1)'(1);
                2'b01:   cnt <= cnt - (PW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// File: rtl/frame_writer.sv
// Raster pixels -> linear framebuffer writes with double-buffer swap; 1 cycle accept-to-write
// when idle, otherwise buffered in a FIFO while fb_ready is low; excess pixels are dropped.
module frame_writer
    import gfx_fb_pkg::*;
#(
    parameter int H_ACTIVE   = H_ACTIVE_DEF,
    parameter int V_ACTIVE   = V_ACTIVE_DEF,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               pix_valid,
    input  logic [COLOR_W-1:0] pix_color,
    input  logic [8:0]         hcount,
    input  logic [7:0]         vcount,
    input  logic               fb_ready,
    output logic               fb_we,
    output logic [ADDR_W-1:0]  fb_addr,
    output logic [COLOR_W-1:0] fb_data,
    output logic               fb_wsel,
    output logic               frame_done,
    output logic               overflow
);
    localparam int         H_LOG = $clog2(H_ACTIVE);
    localparam int         H_PAD = (1 << H_LOG) - H_ACTIVE;
    localparam logic [8:0] H_LIM = 9'(H_ACTIVE);
    localparam logic [8:0] H_END = 9'(H_ACTIVE - 1);
    localparam logic [7:0] V_LIM = 8'(V_ACTIVE);
    localparam logic [7:0] V_END = 8'(V_ACTIVE - 1);

    fw_state_t         state;
    fb_entry_t         push_ent;
    fb_entry_t         head_ent;
    logic [ADDR_W-1:0] pix_addr;
    logic qual, at_origin, is_last;
    logic fifo_full, fifo_empty, fifo_pop, fifo_push;
    logic room, accept, drop, bypass;

    // Row base = v*2^H_LOG - v*H_PAD, so the default 240 becomes (v<<8) - (v<<4).
    assign pix_addr = (ADDR_W'(vcount) << H_LOG) - shift_add(vcount, H_PAD) + ADDR_W'(hcount);

    assign qual      = pix_valid && (hcount < H_LIM) && (vcount < V_LIM);
    assign at_origin = qual && (hcount == '0) && (vcount == '0);
    assign is_last   = (hcount == H_END) && (vcount == V_END);

    assign fifo_pop = fb_ready && !fifo_empty;
    assign room     = !fifo_full || fifo_pop;
    assign accept   = room && (((state == WAIT_SOF) && at_origin) ||
                               ((state == ACTIVE) && qual && !at_origin));
    // A second origin inside a frame means the raster restarted: abandon this frame.
    assign drop      = (state == ACTIVE) && qual && (at_origin || !room);
    assign bypass    = accept && fifo_empty && fb_ready;
    assign fifo_push = accept && !bypass;

    assign push_ent.addr  = pix_addr;
    assign push_ent.color = pix_color;

    fb_wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (fifo_push),
        .push_dat (push_ent),
        .pop      (fifo_pop),
        .pop_dat  (head_ent),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fb_we   <= 1'b0;
            fb_addr <= '0;
            fb_data <= '0;
        end else begin
            fb_we <= fifo_pop || bypass;
            if (fifo_pop) begin
                fb_addr <= head_ent.addr;
                fb_data <= head_ent.color;
            end else if (bypass) begin
                fb_addr <= pix_addr;
                fb_data <= pix_color;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= WAIT_SOF;
            frame_done <= 1'b0;
            fb_wsel    <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (drop) overflow <= 1'b1;
            case (state)
                WAIT_SOF: if (accept) state <= ACTIVE;
                ACTIVE: begin
                    if (at_origin)             state <= FLUSH;
                    else if (accept && is_last) state <= FLUSH;
                end
                // fb_we high means the final write is still on the bus this cycle.
                FLUSH: begin
                    if (fifo_empty && !fb_we) begin
                        state      <= SWAP;
                        frame_done <= 1'b1;
                        fb_wsel    <= ~fb_wsel;
                    end
                end
                SWAP:    state <= WAIT_SOF;
                default: state <= WAIT_SOF;
            endcase
        end
    end
endmodule

// File: tb/tb_frame_writer.sv
// Bench for frame_writer: queue-based reference model feeding a write scoreboard.
module tb_frame_writer;
    localparam int H = 240;
    localparam int V = 160;
    localparam int DEPTH = 4;
    localparam int M_WAIT = 0, M_FRAME = 1, M_DRAIN = 2, M_SWAP = 3;

    logic        clock;
    logic        reset;
    logic        pix_valid;
    logic [14:0] pix_color;
    logic [8:0]  hcount;
    logic [7:0]  vcount;
    logic        fb_ready;
    logic        fb_we;
    logic [16:0] fb_addr;
    logic [14:0] fb_data;
    logic        fb_wsel;
    logic        frame_done;
    logic        overflow;

    frame_writer #(.H_ACTIVE(H), .V_ACTIVE(V), .FIFO_DEPTH(DEPTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .pix_valid  (pix_valid),
        .pix_color  (pix_color),
        .hcount     (hcount),
        .vcount     (vcount),
        .fb_ready   (fb_ready),
        .fb_we      (fb_we),
        .fb_addr    (fb_addr),
        .fb_data    (fb_data),
        .fb_wsel    (fb_wsel),
        .frame_done (frame_done),
        .overflow   (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;
    int wr_count = 0;
    int fd_count = 0;

    logic [31:0] sbq[$];   // writes the framebuffer must see, in order
    logic [31:0] mq[$];    // pixels accepted but still waiting for fb_ready

    int   cur_mode = M_WAIT, nxt_mode = M_WAIT;
    logic cur_we = 1'b0, nxt_we = 1'b0;
    logic cur_fd = 1'b0, nxt_fd = 1'b0;
    logic cur_wsel = 1'b0, nxt_wsel = 1'b0;
    logic cur_ovf = 1'b0, nxt_ovf = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        chk("fb_we", 32'(fb_we), 32'(cur_we));
        chk("frame_done", 32'(frame_done), 32'(cur_fd));
        chk("fb_wsel", 32'(fb_wsel), 32'(cur_wsel));
        chk("overflow", 32'(overflow), 32'(cur_ovf));
        if (fb_we === 1'b1) begin
            wr_count++;
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: got addr %0d data %0h expected none", fb_addr, fb_data);
            end else begin
                chk("write_addr_data", {fb_addr, fb_data}, sbq.pop_front());
            end
        end
        if (frame_done === 1'b1) fd_count++;
    end

    // One raster step of the reference behaviour; writes emitted here appear on fb_we next cycle.
    task automatic model(input logic vld, input logic [8:0] h, input logic [7:0] v,
                         input logic [14:0] c, input logic rdy);
        bit          in_rng, org, emitted, take;
        int          sz0;
        logic [31:0] ent;
        in_rng   = vld && int'(h) < H && int'(v) < V;
        org      = in_rng && h == 9'd0 && v == 8'd0;
        sz0      = mq.size();
        emitted  = 0;
        take     = 0;
        nxt_mode = cur_mode;
        nxt_fd   = 1'b0;
        nxt_wsel = cur_wsel;
        nxt_ovf  = cur_ovf;
        if (rdy && sz0 > 0) begin
            sbq.push_back(mq.pop_front());
            emitted = 1;
        end
        case (cur_mode)
            M_WAIT: if (org) begin take = 1; nxt_mode = M_FRAME; end
            M_FRAME: begin
                if (org) begin
                    nxt_ovf = 1'b1;
                    nxt_mode = M_DRAIN;
                end else if (in_rng) begin
                    if (mq.size() < DEPTH) begin
                        take = 1;
                        if (int'(h) == H - 1 && int'(v) == V - 1) nxt_mode = M_DRAIN;
                    end else begin
                        nxt_ovf = 1'b1;
                    end
                end
            end
            M_DRAIN: begin
                if (sz0 == 0 && !cur_we) begin
                    nxt_mode = M_SWAP;
                    nxt_fd   = 1'b1;
                    nxt_wsel = ~cur_wsel;
                end
            end
            default: nxt_mode = M_WAIT;
        endcase
        if (take) begin
            ent = {17'(int'(v) * H + int'(h)), c};
            if (rdy && !emitted) begin
                sbq.push_back(ent);
                emitted = 1;
            end else begin
                mq.push_back(ent);
            end
        end
        nxt_we = emitted;
    endtask

    task automatic step(input logic vld, input logic [8:0] h, input logic [7:0] v,
                        input logic [14:0] c, input logic rdy);
        @(posedge clock);
        #1;
        cur_mode = nxt_mode; cur_we = nxt_we; cur_fd = nxt_fd;
        cur_wsel = nxt_wsel; cur_ovf = nxt_ovf;
        pix_valid = vld; hcount = h; vcount = v; pix_color = c; fb_ready = rdy;
        model(vld, h, v, c, rdy);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, 9'd0, 8'd0, 15'd0, rdy);
    endtask

    task automatic do_reset();
        @(posedge clock);
        #1;
        reset = 1'b1;
        pix_valid = 1'b0;
        fb_ready = 1'b0;
        mq.delete();
        sbq.delete();
        cur_mode = M_WAIT; cur_we = 1'b0; cur_fd = 1'b0; cur_wsel = 1'b0; cur_ovf = 1'b0;
        nxt_mode = M_WAIT; nxt_we = 1'b0; nxt_fd = 1'b0; nxt_wsel = 1'b0; nxt_ovf = 1'b0;
        #1;
        chk("rst_fb_we", 32'(fb_we), 32'd0);
        chk("rst_fb_addr", 32'(fb_addr), 32'd0);
        chk("rst_fb_data", 32'(fb_data), 32'd0);
        chk("rst_fb_wsel", 32'(fb_wsel), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    int w0, f0;

    initial begin
        reset = 1'b1;
        pix_valid = 1'b0; pix_color = '0; hcount = '0; vcount = '0; fb_ready = 1'b0;
        do_reset();

        // Full frame, framebuffer always ready.
        w0 = wr_count; f0 = fd_count;
        for (int v = 0; v < V; v++)
            for (int h = 0; h < H; h++)
                step(1'b1, 9'(h), 8'(v), 15'($urandom), 1'b1);
        idle(6, 1'b1);
        chk("frame_writes", 32'(wr_count - w0), 32'd38400);
        chk("frame_done_count", 32'(fd_count - f0), 32'd1);
        chk("frame_wsel", 32'(fb_wsel), 32'd1);
        chk("frame_overflow", 32'(overflow), 32'd0);

        // Single pixel latency.
        step(1'b1, 9'd0, 8'd0, 15'h1234, 1'b1);
        step(1'b1, 9'd5, 8'd1, 15'h7C1F, 1'b1);
        idle(1, 1'b1);
        chk("lat_we", 32'(fb_we), 32'd1);
        chk("lat_addr", 32'(fb_addr), 32'd245);
        chk("lat_data", 32'(fb_data), 32'h7C1F);

        // Backpressure: six pixels into a four-entry FIFO.
        for (int i = 0; i < 6; i++) step(1'b1, 9'(i), 8'd2, 15'($urandom), 1'b0);
        idle(1, 1'b0);
        chk("bp_overflow", 32'(overflow), 32'd1);
        w0 = wr_count;
        idle(7, 1'b1);
        chk("bp_writes", 32'(wr_count - w0), 32'd4);

        // Out-of-range pixels.
        do_reset();
        w0 = wr_count;
        step(1'b1, 9'd0, 8'd0, 15'h0001, 1'b1);
        step(1'b1, 9'd240, 8'd10, 15'h0002, 1'b1);
        step(1'b1, 9'd3, 8'd160, 15'h0003, 1'b1);
        idle(3, 1'b1);
        chk("oor_overflow", 32'(overflow), 32'd0);
        chk("oor_writes", 32'(wr_count - w0), 32'd1);

        // Reset with three entries queued.
        for (int i = 0; i < 3; i++) step(1'b1, 9'(10 + i), 8'd3, 15'($urandom), 1'b0);
        w0 = wr_count;
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 9'(1 + i), 8'd0, 15'($urandom), 1'b1);
        idle(2, 1'b1);
        chk("post_reset_writes", 32'(wr_count - w0), 32'd0);

        // Last pixel accepted under backpressure.
        step(1'b1, 9'd0, 8'd0, 15'h0011, 1'b1);
        step(1'b1, 9'd1, 8'd1, 15'h0022, 1'b1);
        step(1'b1, 9'd239, 8'd159, 15'h0033, 1'b0);
        f0 = fd_count;
        idle(8, 1'b0);
        chk("flush_hold_fd", 32'(fd_count - f0), 32'd0);
        chk("flush_hold_wsel", 32'(fb_wsel), 32'd0);
        w0 = wr_count;
        idle(6, 1'b1);
        chk("flush_fd", 32'(fd_count - f0), 32'd1);
        chk("flush_wsel", 32'(fb_wsel), 32'd1);
        chk("flush_writes", 32'(wr_count - w0), 32'd1);

        // Randomised traffic around frame start and end.
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            int          r;
            logic [8:0]  h;
            logic [7:0]  v;
            r = int'($urandom_range(0, 31));
            if (r == 0) begin
                h = 9'd0; v = 8'd0;
            end else if (r == 1) begin
                h = 9'd239; v = 8'd159;
            end else if (r == 2) begin
                h = 9'(240 + $urandom_range(0, 271)); v = 8'($urandom_range(0, 255));
            end else if (r == 3) begin
                h = 9'($urandom_range(0, 239)); v = 8'($urandom_range(160, 255));
            end else begin
                h = 9'($urandom_range(0, 7)); v = 8'($urandom_range(0, 2));
            end
            step($urandom_range(0, 3) != 0, h, v, 15'($urandom), $urandom_range(0, 3) != 0);
        end
        idle(20, 1'b1);
        chk("rand_sb_empty", 32'(sbq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
